// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared INTA sequencer state encoding and ISR decode helper
package pic_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK1  = 2'd1;
    localparam logic [1:0] ST_WAIT2 = 2'd2;
    localparam logic [1:0] ST_ACK2  = 2'd3;

    localparam logic [2:0] SPURIOUS_ID = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - acknowledge, resolver, cascade and data-bus signals of the INTA sequencer
interface inta_sequencer_if;

    logic       INTA_N;
    logic       IRQ_VALID;
    logic [2:0] IRQ_ID;
    logic       SNGL;
    logic       SPEN;
    logic [7:0] SLAVE_MASK;
    logic       CAS_ACK;
    logic [4:0] VECTOR_BASE;
    logic       AEOI;
    logic       FREEZE;
    logic [7:0] ISR_SET;
    logic [7:0] AEOI_CLR;
    logic [2:0] SLAVE_ADRESS;
    logic       CAS_DRIVE;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic       BUSY;
    logic       TIMEOUT_ERR;

    modport master (
        output INTA_N, IRQ_VALID, IRQ_ID, SNGL, SPEN, SLAVE_MASK, CAS_ACK, VECTOR_BASE, AEOI,
        input  FREEZE, ISR_SET, AEOI_CLR, SLAVE_ADRESS, CAS_DRIVE, DATA_OUT, DATA_OE, BUSY, TIMEOUT_ERR
    );

    modport slave (
        input  INTA_N, IRQ_VALID, IRQ_ID, SNGL, SPEN, SLAVE_MASK, CAS_ACK, VECTOR_BASE, AEOI,
        output FREEZE, ISR_SET, AEOI_CLR, SLAVE_ADRESS, CAS_DRIVE, DATA_OUT, DATA_OE, BUSY, TIMEOUT_ERR
    );

endinterface

// File: rtl/inta_edge_detect.sv
// rtl/inta_edge_detect.sv - registers INTA_N and flags its falling and rising edges
module inta_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic INTA_N,
    output logic fall,
    output logic rise
);

    logic inta_q;

    // Resetting to 0 means a strobe held low through reset must go high before it counts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inta_q <= 1'b0;
        end else begin
            inta_q <= INTA_N;
        end
    end

    assign fall = inta_q & ~INTA_N;
    assign rise = ~inta_q & INTA_N;

endmodule

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - 8259 two-pulse interrupt-acknowledge sequencer
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic           CLK,
    input  logic           RST,
    inta_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [2:0]       cur_id;
    logic             cur_valid;
    logic             respond;
    logic             isr_done;
    logic [CNT_W-1:0] cnt;
    logic             fall;
    logic             rise;
    logic             cascade_hit;

    inta_edge_detect u_edge (
        .CLK    (CLK),
        .RST    (RST),
        .INTA_N (bus.INTA_N),
        .fall   (fall),
        .rise   (rise)
    );

    assign cascade_hit = bus.SPEN & bus.IRQ_VALID & bus.SLAVE_MASK[bus.IRQ_ID];
    assign bus.BUSY    = (state != ST_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= ST_IDLE;
            cur_id           <= 3'd0;
            cur_valid        <= 1'b0;
            respond          <= 1'b0;
            isr_done         <= 1'b0;
            cnt              <= '0;
            bus.FREEZE       <= 1'b0;
            bus.ISR_SET      <= 8'h00;
            bus.AEOI_CLR     <= 8'h00;
            bus.SLAVE_ADRESS <= 3'd0;
            bus.CAS_DRIVE    <= 1'b0;
            bus.DATA_OUT     <= 8'h00;
            bus.DATA_OE      <= 1'b0;
            bus.TIMEOUT_ERR  <= 1'b0;
        end else begin
            bus.ISR_SET     <= 8'h00;
            bus.AEOI_CLR    <= 8'h00;
            bus.TIMEOUT_ERR <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state      <= ST_ACK1;
                        cur_id     <= bus.IRQ_VALID ? bus.IRQ_ID : SPURIOUS_ID;
                        cur_valid  <= bus.IRQ_VALID;
                        isr_done   <= 1'b0;
                        bus.FREEZE <= 1'b1;
                        // A slave learns whether it responds only from CAS_ACK at the end of pulse 1.
                        if (bus.SNGL) begin
                            respond <= 1'b1;
                        end else if (bus.SPEN) begin
                            respond          <= ~cascade_hit;
                            bus.CAS_DRIVE    <= cascade_hit;
                            bus.SLAVE_ADRESS <= cascade_hit ? bus.IRQ_ID : 3'd0;
                        end else begin
                            respond <= 1'b0;
                        end
                    end
                end

                ST_ACK1: begin
                    if (rise) begin
                        state <= ST_WAIT2;
                        cnt   <= '0;
                        if (!bus.SNGL && !bus.SPEN) begin
                            respond <= bus.CAS_ACK;
                        end
                        if (cur_valid && (bus.SPEN || bus.SNGL || bus.CAS_ACK)) begin
                            bus.ISR_SET <= onehot8(cur_id);
                            isr_done    <= 1'b1;
                        end
                    end
                end

                ST_WAIT2: begin
                    if (fall) begin
                        state        <= ST_ACK2;
                        bus.DATA_OE  <= respond;
                        bus.DATA_OUT <= respond ? {bus.VECTOR_BASE, cur_id} : 8'h00;
                    end else if (cnt == CNT_LAST) begin
                        // Abort leaves the ISR bit set; software must clear it.
                        state            <= ST_IDLE;
                        cnt              <= '0;
                        bus.TIMEOUT_ERR  <= 1'b1;
                        bus.FREEZE       <= 1'b0;
                        bus.CAS_DRIVE    <= 1'b0;
                        bus.SLAVE_ADRESS <= 3'd0;
                        bus.DATA_OE      <= 1'b0;
                        bus.DATA_OUT     <= 8'h00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_ACK2: begin
                    if (rise) begin
                        state            <= ST_IDLE;
                        bus.FREEZE       <= 1'b0;
                        bus.CAS_DRIVE    <= 1'b0;
                        bus.SLAVE_ADRESS <= 3'd0;
                        bus.DATA_OE      <= 1'b0;
                        bus.DATA_OUT     <= 8'h00;
                        if (bus.AEOI && isr_done) begin
                            bus.AEOI_CLR <= onehot8(cur_id);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - directed-vector bench for inta_sequencer
module tb_inta_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    inta_sequencer_if bus ();

    inta_sequencer #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic inta_low();
        bus.INTA_N = 1'b0;
        tick();
    endtask

    task automatic inta_high();
        bus.INTA_N = 1'b1;
        tick();
    endtask

    task automatic setup(input logic sngl, input logic spen, input logic [7:0] mask,
                         input logic valid, input logic [2:0] id, input logic aeoi);
        bus.SNGL        = sngl;
        bus.SPEN        = spen;
        bus.SLAVE_MASK  = mask;
        bus.IRQ_VALID   = valid;
        bus.IRQ_ID      = id;
        bus.AEOI        = aeoi;
        bus.VECTOR_BASE = 5'b01000;
        bus.CAS_ACK     = 1'b0;
    endtask

    initial begin
        int n;
        bus.INTA_N = 1'b0;
        setup(1'b1, 1'b1, 8'h00, 1'b1, 3'd3, 1'b0);
        tick();
        tick();

        chk("rst_busy", {7'd0, bus.BUSY}, 8'h00);
        chk("rst_freeze", {7'd0, bus.FREEZE}, 8'h00);
        chk("rst_data", bus.DATA_OUT, 8'h00);
        RST = 1'b0;
        tick();
        chk("low_thru_reset", {7'd0, bus.BUSY}, 8'h00);
        inta_high();
        tick();

        // single mode, IR3
        inta_low();
        chk("s_freeze1", {7'd0, bus.FREEZE}, 8'h01);
        chk("s_isr_early", bus.ISR_SET, 8'h00);
        bus.IRQ_ID = 3'd6;
        inta_high();
        chk("s_isr", bus.ISR_SET, 8'h08);
        tick();
        chk("s_isr_pulse", bus.ISR_SET, 8'h00);
        chk("s_freeze_w", {7'd0, bus.FREEZE}, 8'h01);
        inta_low();
        chk("s_oe", {7'd0, bus.DATA_OE}, 8'h01);
        chk("s_vec", bus.DATA_OUT, 8'h43);
        chk("s_freeze2", {7'd0, bus.FREEZE}, 8'h01);
        inta_high();
        chk("s_oe_end", {7'd0, bus.DATA_OE}, 8'h00);
        chk("s_freeze_end", {7'd0, bus.FREEZE}, 8'h00);
        chk("s_busy_end", {7'd0, bus.BUSY}, 8'h00);
        tick();

        // master with slave on IR2
        setup(1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0);
        inta_low();
        chk("m_addr1", {5'd0, bus.SLAVE_ADRESS}, 8'h02);
        chk("m_cas1", {7'd0, bus.CAS_DRIVE}, 8'h01);
        inta_high();
        chk("m_isr", bus.ISR_SET, 8'h04);
        tick();
        inta_low();
        chk("m_addr2", {5'd0, bus.SLAVE_ADRESS}, 8'h02);
        chk("m_cas2", {7'd0, bus.CAS_DRIVE}, 8'h01);
        chk("m_oe", {7'd0, bus.DATA_OE}, 8'h00);
        inta_high();
        chk("m_cas_end", {7'd0, bus.CAS_DRIVE}, 8'h00);
        chk("m_addr_end", {5'd0, bus.SLAVE_ADRESS}, 8'h00);
        tick();

        // slave, matched, AEOI
        setup(1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1);
        inta_low();
        bus.CAS_ACK = 1'b1;
        inta_high();
        bus.CAS_ACK = 1'b0;
        chk("sl_isr", bus.ISR_SET, 8'h20);
        tick();
        inta_low();
        chk("sl_oe", {7'd0, bus.DATA_OE}, 8'h01);
        chk("sl_vec", bus.DATA_OUT, 8'h45);
        inta_high();
        chk("sl_aeoi", bus.AEOI_CLR, 8'h20);
        tick();
        chk("sl_aeoi_pulse", bus.AEOI_CLR, 8'h00);

        // slave, not matched
        setup(1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1);
        inta_low();
        chk("sn_oe1", {7'd0, bus.DATA_OE}, 8'h00);
        inta_high();
        chk("sn_isr", bus.ISR_SET, 8'h00);
        tick();
        inta_low();
        chk("sn_oe2", {7'd0, bus.DATA_OE}, 8'h00);
        chk("sn_busy", {7'd0, bus.BUSY}, 8'h01);
        inta_high();
        chk("sn_busy_end", {7'd0, bus.BUSY}, 8'h00);
        chk("sn_aeoi", bus.AEOI_CLR, 8'h00);
        tick();

        // spurious, single mode
        setup(1'b1, 1'b1, 8'h00, 1'b0, 3'd3, 1'b1);
        inta_low();
        inta_high();
        chk("sp_isr", bus.ISR_SET, 8'h00);
        tick();
        inta_low();
        chk("sp_vec", bus.DATA_OUT, 8'h47);
        chk("sp_oe", {7'd0, bus.DATA_OE}, 8'h01);
        inta_high();
        chk("sp_aeoi", bus.AEOI_CLR, 8'h00);
        tick();

        // timeout after pulse 1 only
        setup(1'b1, 1'b1, 8'h00, 1'b1, 3'd1, 1'b0);
        inta_low();
        inta_high();
        chk("to_isr", bus.ISR_SET, 8'h02);
        n = 0;
        while (bus.TIMEOUT_ERR !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("to_delay", 8'(n), 8'd64);
        chk("to_busy", {7'd0, bus.BUSY}, 8'h00);
        chk("to_freeze", {7'd0, bus.FREEZE}, 8'h00);
        tick();
        chk("to_pulse", {7'd0, bus.TIMEOUT_ERR}, 8'h00);

        // reset during ACK2
        setup(1'b1, 1'b1, 8'h00, 1'b1, 3'd4, 1'b1);
        inta_low();
        inta_high();
        tick();
        inta_low();
        chk("ra_oe_pre", {7'd0, bus.DATA_OE}, 8'h01);
        RST = 1'b1;
        #1;
        chk("ra_oe", {7'd0, bus.DATA_OE}, 8'h00);
        chk("ra_data", bus.DATA_OUT, 8'h00);
        chk("ra_freeze", {7'd0, bus.FREEZE}, 8'h00);
        chk("ra_busy", {7'd0, bus.BUSY}, 8'h00);
        inta_high();
        chk("ra_aeoi1", bus.AEOI_CLR, 8'h00);
        RST = 1'b0;
        tick();
        chk("ra_aeoi2", bus.AEOI_CLR, 8'h00);
        chk("ra_busy2", {7'd0, bus.BUSY}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
